i2s_master_param: RTL and testbench



---
 rtl/i2s_master_param.sv | 168 ++++++++++++++++
 tb/tb_i2s_master_param.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/i2s_master_param.sv
// I2S / left-justified audio master: derives bclk and lrclk from mclk, serialises tx_l/tx_r on sdout and captures sdin.
// Optional build macro I2S_LOOPBACK_EN: the receiver samples the internal sdout register instead of sdin.
module i2s_master_param #(
  parameter int BCLK_HALF = 12,
  parameter int SLOT_BITS = 32,
  parameter int DATA_BITS = 32
) (
  input  logic                 mclk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 fmt,
  output logic                 lrclk,
  output logic                 bclk,
  output logic                 sdout,
  input  logic                 sdin,
  input  logic [DATA_BITS-1:0] tx_l,
  input  logic [DATA_BITS-1:0] tx_r,
  output logic                 tx_ack,
  output logic [DATA_BITS-1:0] rx_l,
  output logic [DATA_BITS-1:0] rx_r,
  output logic                 rx_valid
);

  localparam int CNT_W = $clog2(2*BCLK_HALF);
  localparam int IDX_W = $clog2(2*SLOT_BITS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(2*BCLK_HALF-1);
  localparam logic [CNT_W-1:0] CNT_RISE = CNT_W'(BCLK_HALF);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(2*SLOT_BITS-1);

  logic [CNT_W-1:0]     cnt;
  logic [IDX_W-1:0]     bit_idx;
  logic                 fmt_lat;
  logic [DATA_BITS-1:0] tx_l_lat;
  logic [DATA_BITS-1:0] tx_r_lat;
  logic [DATA_BITS-1:0] rx_sh_l;
  logic [DATA_BITS-1:0] rx_sh_r;
  logic                 started;
  logic                 prev_live;
  logic                 rx_done;

  logic                 frame_start;
  logic                 fmt_eff;
  logic [DATA_BITS-1:0] l_eff;
  logic                 tx_bit;
  logic                 lr_nxt;
  logic                 rx_bit;
  logic [IDX_W-1:0]     rx_pos;
  logic                 rx_right;
  int                   rx_k;
  logic                 rx_in_data;
  logic                 rx_last;

  // Frame position of the bit carried in bit_idx; I2S runs one bclk behind, so its bit 0 is the previous right LSB.
  function automatic logic [IDX_W-1:0] slot_pos(input logic lj, input logic [IDX_W-1:0] idx);
    if (lj) return idx;
    if (idx == '0) return IDX_LAST;
    return idx - IDX_W'(1);
  endfunction

  function automatic logic pick_bit(input logic [DATA_BITS-1:0] l, input logic [DATA_BITS-1:0] r,
                                    input logic lj, input logic [IDX_W-1:0] idx);
    logic [IDX_W-1:0]     pos;
    logic [DATA_BITS-1:0] word;
    int                   k;
    pos  = slot_pos(lj, idx);
    k    = int'(pos);
    word = l;
    if (k >= SLOT_BITS) begin
      word = r;
      k    = k - SLOT_BITS;
    end
    if (k >= DATA_BITS) return 1'b0;
    word = word >> (DATA_BITS - 1 - k);
    return word[0];
  endfunction

`ifdef I2S_LOOPBACK_EN
  logic unused_sdin;
  assign unused_sdin = sdin;
  assign rx_bit = sdout;
`else
  assign rx_bit = sdin;
`endif

  // At frame start the inputs being latched this edge already govern the first driven bit.
  always_comb begin
    frame_start = en && (cnt == '0) && (bit_idx == '0);
    fmt_eff     = frame_start ? fmt : fmt_lat;
    l_eff       = frame_start ? tx_l : tx_l_lat;
    tx_bit      = pick_bit(l_eff, tx_r_lat, fmt_eff, bit_idx);
    lr_nxt      = (int'(bit_idx) < SLOT_BITS) ? fmt_eff : !fmt_eff;
    rx_pos      = slot_pos(fmt_lat, bit_idx);
    rx_right    = int'(rx_pos) >= SLOT_BITS;
    rx_k        = rx_right ? int'(rx_pos) - SLOT_BITS : int'(rx_pos);
    rx_in_data  = rx_k < DATA_BITS;
    rx_last     = rx_right && (rx_k == DATA_BITS - 1);
  end

  // prev_live guards the I2S right-LSB that lands in bit 0: it only completes a word if the prior frame ran in I2S.
  always_ff @(posedge mclk) begin
    if (rst) begin
      cnt       <= '0;
      bit_idx   <= '0;
      bclk      <= 1'b0;
      lrclk     <= 1'b0;
      sdout     <= 1'b0;
      tx_ack    <= 1'b0;
      rx_valid  <= 1'b0;
      rx_l      <= '0;
      rx_r      <= '0;
      rx_sh_l   <= '0;
      rx_sh_r   <= '0;
      fmt_lat   <= 1'b0;
      tx_l_lat  <= '0;
      tx_r_lat  <= '0;
      started   <= 1'b0;
      prev_live <= 1'b0;
      rx_done   <= 1'b0;
    end else if (!en) begin
      cnt       <= '0;
      bit_idx   <= '0;
      bclk      <= 1'b0;
      lrclk     <= fmt;
      sdout     <= 1'b0;
      tx_ack    <= 1'b0;
      rx_valid  <= 1'b0;
      tx_l_lat  <= '0;
      tx_r_lat  <= '0;
      started   <= 1'b0;
      prev_live <= 1'b0;
      rx_done   <= 1'b0;
    end else begin
      if (cnt == CNT_LAST) begin
        cnt     <= '0;
        bit_idx <= (bit_idx == IDX_LAST) ? '0 : bit_idx + IDX_W'(1);
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
      bclk   <= (cnt >= CNT_RISE);
      tx_ack <= frame_start;

      if (cnt == '0) begin
        sdout <= tx_bit;
        lrclk <= lr_nxt;
      end

      if (frame_start) begin
        fmt_lat   <= fmt;
        tx_l_lat  <= tx_l;
        tx_r_lat  <= tx_r;
        prev_live <= started && !fmt_lat;
        started   <= 1'b1;
      end

      if ((cnt == CNT_RISE) && rx_in_data) begin
        if (rx_right) rx_sh_r <= {rx_sh_r[DATA_BITS-2:0], rx_bit};
        else          rx_sh_l <= {rx_sh_l[DATA_BITS-2:0], rx_bit};
      end
      rx_done  <= (cnt == CNT_RISE) && rx_in_data && rx_last && ((bit_idx != '0) || prev_live);
      rx_valid <= rx_done;
      if (rx_done) begin
        rx_l <= rx_sh_l;
        rx_r <= rx_sh_r;
      end
    end
  end

endmodule

// File: tb/tb_i2s_master_param.sv
// Directed bench for i2s_master_param (BCLK_HALF=2, SLOT_BITS=8): 8-bit instance with sdout looped to sdin, 6-bit instance with padded slots.
module tb_i2s_master_param;

  logic       mclk;
  logic       rst;
  logic       en;
  logic       fmt;
  logic       sdin;
  logic       sdout;
  logic       bclk;
  logic       lrclk;
  logic       tx_ack;
  logic       rx_valid;
  logic [7:0] tx_l;
  logic [7:0] tx_r;
  logic [7:0] rx_l;
  logic [7:0] rx_r;

  logic       sdin6;
  logic       sdout6;
  logic       bclk6;
  logic       lrclk6;
  logic       tx_ack6;
  logic       rx_valid6;
  logic       pad6;
  logic [5:0] tx_l6;
  logic [5:0] tx_r6;
  logic [5:0] rx_l6;
  logic [5:0] rx_r6;

  int tests;
  int fails;

  assign sdin  = sdout;
  assign sdin6 = pad6 ? 1'b1 : sdout6;

  i2s_master_param #(.BCLK_HALF(2), .SLOT_BITS(8), .DATA_BITS(8)) dut (
    .mclk(mclk), .rst(rst), .en(en), .fmt(fmt), .lrclk(lrclk), .bclk(bclk), .sdout(sdout), .sdin(sdin),
    .tx_l(tx_l), .tx_r(tx_r), .tx_ack(tx_ack), .rx_l(rx_l), .rx_r(rx_r), .rx_valid(rx_valid)
  );

  i2s_master_param #(.BCLK_HALF(2), .SLOT_BITS(8), .DATA_BITS(6)) dut6 (
    .mclk(mclk), .rst(rst), .en(en), .fmt(fmt), .lrclk(lrclk6), .bclk(bclk6), .sdout(sdout6), .sdin(sdin6),
    .tx_l(tx_l6), .tx_r(tx_r6), .tx_ack(tx_ack6), .rx_l(rx_l6), .rx_r(rx_r6), .rx_valid(rx_valid6)
  );

  initial mclk = 1'b0;
  always #5 mclk = ~mclk;

  task automatic tick();
    @(posedge mclk);
    #1;
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Expected sdout for bclk k of an 8-bit frame; pr is the previous frame's right sample.
  function automatic logic exp_bit(input logic f, input logic [7:0] l, input logic [7:0] r,
                                   input logic [7:0] pr, input int k);
    logic [7:0] w;
    if (f) begin
      w = (k < 8) ? (l >> (7 - k)) : (r >> (15 - k));
    end else if (k == 0) begin
      w = pr;
    end else begin
      w = (k <= 8) ? (l >> (8 - k)) : (r >> (16 - k));
    end
    return w[0];
  endfunction

  // Expected sdout for the 6-bit instance in left-justified mode.
  function automatic logic exp_bit6(input logic [5:0] l, input logic [5:0] r, input int k);
    logic [5:0] w;
    int m;
    m = k % 8;
    if (m >= 6) return 1'b0;
    w = (k < 8) ? l : r;
    w = w >> (5 - m);
    return w[0];
  endfunction

  task automatic run_frame(input logic f, input logic [7:0] l, input logic [7:0] r, input logic [7:0] pr,
                           input int n, input int rxv_at, input logic [7:0] erl, input logic [7:0] err,
                           input int chg_at, input logic cf, input logic [7:0] cl, input logic [7:0] cr,
                           input bit chk6);
    for (int i = 0; i < n; i++) begin
      int k;
      k = i / 4;
      pad6 = f && ((k % 8) >= 6);
      check1($sformatf("bclk[%0d]", i), bclk, (i % 4) >= 2);
      check1($sformatf("tx_ack[%0d]", i), tx_ack, i == 0);
      check1($sformatf("lrclk[%0d]", i), lrclk, f ? (k < 8) : (k >= 8));
      check1($sformatf("sdout[%0d]", i), sdout, exp_bit(f, l, r, pr, k));
      check1($sformatf("rx_valid[%0d]", i), rx_valid, i == rxv_at);
      if (i == rxv_at) begin
        check8("rx_l", rx_l, erl);
        check8("rx_r", rx_r, err);
      end
      if (chk6) begin
        check1($sformatf("bclk6[%0d]", i), bclk6, (i % 4) >= 2);
        check1($sformatf("lrclk6[%0d]", i), lrclk6, k < 8);
        check1($sformatf("tx_ack6[%0d]", i), tx_ack6, i == 0);
        check1($sformatf("sdout6[%0d]", i), sdout6, exp_bit6(tx_l6, tx_r6, k));
        check1($sformatf("rx_valid6[%0d]", i), rx_valid6, i == 55);
        if (i == 55) begin
          check8("rx_l6", {2'b00, rx_l6}, 8'h2B);
          check8("rx_r6", {2'b00, rx_r6}, 8'h15);
        end
      end
      if (i == chg_at) begin
        fmt  = cf;
        tx_l = cl;
        tx_r = cr;
      end
      tick();
    end
    pad6 = 1'b0;
  endtask

  task automatic check_quiet(input string tag, input logic exp_lr);
    check1({tag, "_bclk"}, bclk, 1'b0);
    check1({tag, "_lrclk"}, lrclk, exp_lr);
    check1({tag, "_sdout"}, sdout, 1'b0);
    check1({tag, "_tx_ack"}, tx_ack, 1'b0);
    check1({tag, "_rx_valid"}, rx_valid, 1'b0);
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst   = 1'b1;
    en    = 1'b0;
    fmt   = 1'b0;
    tx_l  = 8'h00;
    tx_r  = 8'h00;
    pad6  = 1'b0;
    tx_l6 = 6'h2B;
    tx_r6 = 6'h15;
    repeat (3) tick();

    // Reset must win over en and the LJ idle level.
    en  = 1'b1;
    fmt = 1'b1;
    tick();
    check_quiet("reset", 1'b0);
    check8("reset_rx_l", rx_l, 8'h00);
    check8("reset_rx_r", rx_r, 8'h00);

    rst = 1'b0;
    en  = 1'b0;
    tick();
    check_quiet("idle_lj", 1'b1);
    fmt = 1'b0;
    tick();
    check_quiet("idle_i2s", 1'b0);

    // Frame A: LJ; fmt switched to I2S mid-frame only affects frame B.
    fmt  = 1'b1;
    tx_l = 8'hA5;
    tx_r = 8'h3C;
    en   = 1'b1;
    tick();
    run_frame(1'b1, 8'hA5, 8'h3C, 8'h00, 64, 63, 8'hA5, 8'h3C, 10, 1'b0, 8'hA5, 8'h3C, 1'b1);
    run_frame(1'b0, 8'hA5, 8'h3C, 8'h3C, 64, -1, 8'h00, 8'h00, 10, 1'b0, 8'h81, 8'h7E, 1'b0);
    run_frame(1'b0, 8'h81, 8'h7E, 8'h3C, 64, 3, 8'hA5, 8'h3C, -1, 1'b0, 8'h00, 8'h00, 1'b0);
    run_frame(1'b0, 8'h81, 8'h7E, 8'h7E, 64, 3, 8'h81, 8'h7E, -1, 1'b0, 8'h00, 8'h00, 1'b0);

    // Reset lands on the cycle a receive completion is pending.
    run_frame(1'b0, 8'h81, 8'h7E, 8'h7E, 2, -1, 8'h00, 8'h00, -1, 1'b0, 8'h00, 8'h00, 1'b0);
    rst = 1'b1;
    tick();
    check_quiet("abort", 1'b0);
    check8("abort_rx_l", rx_l, 8'h00);
    check8("abort_rx_r", rx_r, 8'h00);
    tick();
    check_quiet("abort2", 1'b0);

    // Partial LJ frame, then en drop and a fresh frame.
    rst = 1'b0;
    fmt = 1'b1;
    en  = 1'b1;
    tick();
    run_frame(1'b1, 8'h81, 8'h7E, 8'h00, 30, -1, 8'h00, 8'h00, -1, 1'b1, 8'h81, 8'h7E, 1'b0);
    en = 1'b0;
    tick();
    check_quiet("drop_lj", 1'b1);
    fmt = 1'b0;
    tick();
    check_quiet("drop_i2s", 1'b0);
    fmt  = 1'b1;
    tx_l = 8'h5A;
    tx_r = 8'hC3;
    en   = 1'b1;
    tick();
    run_frame(1'b1, 8'h5A, 8'hC3, 8'h00, 64, 63, 8'h5A, 8'hC3, -1, 1'b1, 8'h5A, 8'hC3, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
